mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative signed multiply/divide engine serving the MULT and DIV R-type instructions of the multi-cycle CPU.
- Upstream, the control unit issues one-cycle start pulses; the datapath A/B registers supply the operands.
- Downstream, the HI/LO registers capture hi_out/lo_out, gated by the control unit on a done pulse.
- Results hold stable after done until the next accepted start, because the control unit writes HI/LO one state after div_done.

Parameters:
WIDTH, 32, operand width; hi_out/lo_out are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
mult_start  input  1  one-cycle pulse that starts a signed multiply of a_in*b_in.
div_start  input  1  one-cycle pulse that starts a signed divide of a_in/b_in.
a_in  input  WIDTH  rs operand (multiplicand / dividend); sampled on the accepting edge only.
b_in  input  WIDTH  rt operand (multiplier / divisor); sampled on the accepting edge only.
hi_out  output  WIDTH  MULT: product[63:32]. DIV: remainder.
lo_out  output  WIDTH  MULT: product[31:0]. DIV: quotient.
mult_done  output  1  one-cycle pulse; multiply result valid.
div_done  output  1  one-cycle pulse; divide result valid.
div_zero  output  1  set with div_done when the divisor was 0; held until the next accepted start.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; hi_out=lo_out=0; mult_done=div_done=div_zero=0; busy=0; counter=0.
  - The operation in flight is discarded.
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE_M, DONE_D.
- IDLE:
  - mult_start=1 -> MUL_RUN; latch operands; counter=0.
  - else div_start=1 and b_in!=0 -> DIV_RUN; latch |a|, |b| and both sign bits.
  - else div_start=1 and b_in==0 -> DONE_D with div_zero=1, lo_out=all ones, hi_out=a_in.
  - Starting any operation clears div_zero.
- Simultaneous mult_start and div_start in IDLE: multiply wins; the divide request is dropped.
- Starts outside IDLE (busy=1) are ignored with no side effect.
- MUL_RUN: radix-2 Booth on a 2*WIDTH+1 accumulator, one step per cycle, WIDTH cycles, then DONE_M.
- DIV_RUN: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles, then DIV_FIX.
- DIV_FIX: sign correction.
  - Quotient is negated if sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - Go to DONE_D.
- Overflow case -2^(WIDTH-1) / -1: lo_out=0x8000_0000, hi_out=0 (natural 32-bit wrap). No flag.
- DONE_M / DONE_D:
  - hi_out/lo_out are updated on the edge entering DONE_x.
  - The matching done output is high for exactly that one cycle; the next state is IDLE.
- hi_out/lo_out never change outside the DONE-entry edge and reset.
- Latency, counted in edges from the edge that samples the start pulse to the edge that raises done:
  - multiply: WIDTH+1 = 33;
  - divide: WIDTH+2 = 34;
  - divide by zero: 1.
- Earliest next start: the cycle after done, i.e. the first IDLE cycle.

Optional Feature:
- Macro MULT_DIV_FAST_MULT_EN.
- When defined:
  - MUL_RUN becomes a single cycle that computes the full signed 2*WIDTH product with a combinational multiplier.
  - mult_done is raised 2 edges after the start edge.
  - The divide path is unchanged.
- When undefined: iterative Booth multiply with 33-edge latency; no hardware multiplier is inferred.

Test Plan:
- mult_start, a=7, b=-3 -> mult_done high exactly 33 edges later for 1 cycle; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; busy low the next cycle.
- div_start, a=-17, b=5 -> div_done at edge 34; lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFE (-2), div_zero=0; values hold 10 cycles after done.
- div_start, a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0; then div_start, a=42, b=0 -> div_done 1 edge later, div_zero=1, lo=0xFFFF_FFFF, hi=42.
- mult_start and div_start in the same cycle with a=0x0001_0000, b=0x0001_0000 -> only mult_done fires, hi=1, lo=0. A div_start pulsed at edge 10 of that multiply is ignored; no div_done appears.
- reset asserted asynchronously at edge 15 of a divide -> outputs immediately 0, state IDLE. A new mult_start, a=b=0x7FFF_FFFF, yields hi=0x3FFF_FFFF, lo=0x0000_0001.
- With MULT_DIV_FAST_MULT_EN: mult_start, a=-2, b=-2 -> mult_done 2 edges later, hi=0, lo=4; divide latency is still 34.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply / divide engine for the MULT and DIV
// instructions of the multi-cycle CPU.
//   - Multiply: radix-2 Booth, one step per cycle (WIDTH steps).
//   - Divide: restoring division on magnitudes, one quotient bit per cycle,
//     followed by a sign-correction cycle.
//   - Divide by zero finishes immediately with div_zero set.
// Optional build macro MULT_DIV_FAST_MULT_EN: replaces the Booth iteration with
// a single-cycle combinational signed multiplier (divide path unchanged).
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_done,
    output logic             div_done,
    output logic             div_zero,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_RUN = 3'd1,
        DIV_RUN = 3'd2,
        DIV_FIX = 3'd3,
        DONE_M  = 3'd4,
        DONE_D  = 3'd5
    } state_t;

    // Booth accumulator: guard bit + upper WIDTH + multiplier WIDTH + q(-1) bit.
    // The guard bit keeps the upper partial sum from overflowing when the
    // multiplicand is the most negative value.
    localparam int AW = 2*WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH-1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]    acc_reg, acc_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic             sa_reg, sa_next;
    logic             sb_reg, sb_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             dz_reg, dz_next;

    // Operand magnitudes for the divider (most negative value maps to itself,
    // which is its correct unsigned magnitude)
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

`ifdef MULT_DIV_FAST_MULT_EN
    // Full-width signed product of the latched operands
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = $signed({{WIDTH{mcand_reg[WIDTH-1]}}, mcand_reg})
                     * $signed({{WIDTH{acc_reg[WIDTH]}}, acc_reg[WIDTH:1]});
`else
    // One radix-2 Booth step: add/subtract multiplicand by the recoded pair,
    // then arithmetic shift right of the whole accumulator
    logic [WIDTH:0]  booth_m;
    logic [WIDTH:0]  booth_upper;
    logic [AW-1:0]   booth_acc;
    always_comb begin
        booth_m     = {mcand_reg[WIDTH-1], mcand_reg};
        booth_upper = acc_reg[AW-1:WIDTH+1];
        case (acc_reg[1:0])
            2'b01:   booth_upper = booth_upper + booth_m;
            2'b10:   booth_upper = booth_upper - booth_m;
            default: booth_upper = acc_reg[AW-1:WIDTH+1];
        endcase
        booth_acc = $signed({booth_upper, acc_reg[WIDTH:0]}) >>> 1;
    end
`endif

    // One restoring-division step: shift in the next dividend bit and try to
    // subtract the divisor; a negative difference means keep the shifted value
    logic [WIDTH:0] div_shift, div_diff;
    always_comb begin
        div_shift = {rem_reg, quo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs_reg};
    end

    // Sign correction: quotient negative when signs differ, remainder follows dividend
    logic [WIDTH-1:0] q_fix, r_fix;
    assign q_fix = (sa_reg ^ sb_reg) ? -quo_reg : quo_reg;
    assign r_fix = sa_reg ? -rem_reg : rem_reg;

    // Next-state and datapath update logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        mcand_next = mcand_reg;
        quo_next   = quo_reg;
        rem_next   = rem_reg;
        dvs_next   = dvs_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        dz_next    = dz_reg;
        case (state_reg)
            IDLE: begin
                if (mult_start) begin
                    // Multiply has priority over a simultaneous divide request
                    state_next = MUL_RUN;
                    cnt_next   = '0;
                    mcand_next = a_in;
                    acc_next   = {{(WIDTH+1){1'b0}}, b_in, 1'b0};
                    dz_next    = 1'b0;
                end else if (div_start) begin
                    if (b_in == '0) begin
                        state_next = DONE_D;
                        dz_next    = 1'b1;
                        lo_next    = '1;
                        hi_next    = a_in;
                    end else begin
                        state_next = DIV_RUN;
                        cnt_next   = '0;
                        quo_next   = a_mag;
                        rem_next   = '0;
                        dvs_next   = b_mag;
                        sa_next    = a_in[WIDTH-1];
                        sb_next    = b_in[WIDTH-1];
                        dz_next    = 1'b0;
                    end
                end
            end
            MUL_RUN: begin
`ifdef MULT_DIV_FAST_MULT_EN
                state_next         = DONE_M;
                {hi_next, lo_next} = fast_prod;
`else
                acc_next = booth_acc;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP) begin
                    state_next = DONE_M;
                    hi_next    = booth_acc[2*WIDTH:WIDTH+1];
                    lo_next    = booth_acc[WIDTH:1];
                end
`endif
            end
            DIV_RUN: begin
                if (div_diff[WIDTH]) begin
                    rem_next = div_shift[WIDTH-1:0];
                    quo_next = {quo_reg[WIDTH-2:0], 1'b0};
                end else begin
                    rem_next = div_diff[WIDTH-1:0];
                    quo_next = {quo_reg[WIDTH-2:0], 1'b1};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_STEP) begin
                    state_next = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_next = DONE_D;
                hi_next    = r_fix;
                lo_next    = q_fix;
            end
            DONE_M, DONE_D: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mcand_reg <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            dz_reg    <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            mcand_reg <= mcand_next;
            quo_reg   <= quo_next;
            rem_reg   <= rem_next;
            dvs_reg   <= dvs_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            dz_reg    <= dz_next;
        end
    end

    assign hi_out    = hi_reg;
    assign lo_out    = lo_reg;
    assign div_zero  = dz_reg;
    assign mult_done = (state_reg == DONE_M);
    assign div_done  = (state_reg == DONE_D);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
// Latencies are counted in clock edges, the edge that samples the start pulse
// being edge 1.
module tb_mult_div_unit;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
    localparam int INJ_EDGE = 2;
`else
    localparam int MUL_LAT = 33;
    localparam int INJ_EDGE = 10;
`endif
    localparam int DIV_LAT = 34;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        mult_done;
    logic        div_done;
    logic        div_zero;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .mult_done  (mult_done),
        .div_done   (div_done),
        .div_zero   (div_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse in an IDLE cycle and wait (bounded) for a done pulse.
    // Returns at 1 time unit after the done edge; edges = -1 on timeout.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output logic saw_m, output logic saw_d);
        @(posedge clk);
        @(negedge clk);
        mult_start = m;
        div_start  = d;
        a_in       = a;
        b_in       = b;
        edges = -1;
        saw_m = 1'b0;
        saw_d = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            mult_start = 1'b0;
            div_start  = 1'b0;
            if (mult_done || div_done) begin
                edges = k;
                saw_m = mult_done;
                saw_d = div_done;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mult_start = 1'b0;
        div_start = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({hi_out, lo_out} !== 64'h0) begin
            failures++;
            $display("FAIL reset_hilo: got hi=%h lo=%h, want 0/0", hi_out, lo_out);
        end
        checks++;
        if ({mult_done, div_done, div_zero, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got md=%b dd=%b dz=%b busy=%b, want all 0",
                     mult_done, div_done, div_zero, busy);
        end
        $display("txn reset: hi=%h lo=%h busy=%b", hi_out, lo_out, busy);
    endtask

    task automatic test_mult_basic;
        int   edges;
        logic sm, sd;
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, edges, sm, sd);
        $display("txn mult 7*-3: edges=%0d hi=%h lo=%h", edges, hi_out, lo_out);
        checks++;
        if (edges !== MUL_LAT || sm !== 1'b1 || sd !== 1'b0) begin
            failures++;
            $display("FAIL mult_latency: got edges=%0d md=%b dd=%b, want %0d/1/0", edges, sm, sd, MUL_LAT);
        end
        checks++;
        if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
            failures++;
            $display("FAIL mult_7x-3: got hi=%h lo=%h, want ffffffff/ffffffeb", hi_out, lo_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (mult_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mult_done_pulse: got md=%b busy=%b one cycle after done, want 0/0", mult_done, busy);
        end
    endtask

    task automatic test_div_signed;
        int   edges;
        int   hold_bad;
        logic sm, sd;
        run_op(1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5, edges, sm, sd);
        $display("txn div -17/5: edges=%0d hi=%h lo=%h dz=%b", edges, hi_out, lo_out, div_zero);
        checks++;
        if (edges !== DIV_LAT || sd !== 1'b1 || sm !== 1'b0) begin
            failures++;
            $display("FAIL div_latency: got edges=%0d dd=%b md=%b, want %0d/1/0", edges, sd, sm, DIV_LAT);
        end
        checks++;
        if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFE || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_-17/5: got lo=%h hi=%h dz=%b, want fffffffd/fffffffe/0", lo_out, hi_out, div_zero);
        end
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            a_in = 32'h1234_0000 + i;
            b_in = 32'h0000_0003;
            @(posedge clk);
            #1;
            if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'hFFFF_FFFD) hold_bad++;
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++;
            $display("FAIL div_hold: got %0d cycles with changed results, want 0 (hi=%h lo=%h)", hold_bad, hi_out, lo_out);
        end
    endtask

    task automatic test_div_overflow_zero;
        int   edges;
        logic sm, sd;
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, sm, sd);
        $display("txn div min/-1: edges=%0d hi=%h lo=%h", edges, hi_out, lo_out);
        checks++;
        if (edges !== DIV_LAT || lo_out !== 32'h8000_0000 || hi_out !== 32'h0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_overflow: got edges=%0d lo=%h hi=%h dz=%b, want %0d/80000000/0/0",
                     edges, lo_out, hi_out, div_zero, DIV_LAT);
        end
        run_op(1'b0, 1'b1, 32'd42, 32'd0, edges, sm, sd);
        $display("txn div 42/0: edges=%0d hi=%h lo=%h dz=%b", edges, hi_out, lo_out, div_zero);
        checks++;
        if (edges !== 1 || sd !== 1'b1) begin
            failures++;
            $display("FAIL divzero_latency: got edges=%0d dd=%b, want 1/1", edges, sd);
        end
        checks++;
        if (div_zero !== 1'b1 || lo_out !== 32'hFFFF_FFFF || hi_out !== 32'd42) begin
            failures++;
            $display("FAIL divzero_result: got dz=%b lo=%h hi=%h, want 1/ffffffff/0000002a", div_zero, lo_out, hi_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (div_done !== 1'b0 || div_zero !== 1'b1) begin
            failures++;
            $display("FAIL divzero_hold: got dd=%b dz=%b next cycle, want 0/1", div_done, div_zero);
        end
    endtask

    task automatic test_simultaneous;
        int   edges;
        logic d_seen;
        logic [31:0] hi_cap, lo_cap;
        @(negedge clk);
        mult_start = 1'b1;
        div_start  = 1'b1;
        a_in = 32'h0001_0000;
        b_in = 32'h0001_0000;
        edges = -1;
        d_seen = 1'b0;
        hi_cap = '0;
        lo_cap = '0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                checks++;
                if (div_zero !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL start_clears_dz: got dz=%b busy=%b after start, want 0/1", div_zero, busy);
                end
            end
            mult_start = 1'b0;
            div_start  = (k + 1 == INJ_EDGE);
            if (k + 1 == INJ_EDGE) begin
                a_in = 32'd5;
                b_in = 32'd0;
            end
            if (div_done) d_seen = 1'b1;
            if (mult_done && edges < 0) begin
                edges = k;
                hi_cap = hi_out;
                lo_cap = lo_out;
            end
            if (edges > 0 && k >= edges + 2) break;
        end
        div_start = 1'b0;
        $display("txn mult+div same cycle: edges=%0d hi=%h lo=%h div_done_seen=%b", edges, hi_cap, lo_cap, d_seen);
        checks++;
        if (edges !== MUL_LAT || hi_cap !== 32'h1 || lo_cap !== 32'h0) begin
            failures++;
            $display("FAIL simul_mult: got edges=%0d hi=%h lo=%h, want %0d/1/0", edges, hi_cap, lo_cap, MUL_LAT);
        end
        checks++;
        if (d_seen !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_ignored: got div_done_seen=%b dz=%b, want 0/0", d_seen, div_zero);
        end
    endtask

    task automatic test_async_reset;
        int   edges;
        logic sm, sd;
        @(negedge clk);
        div_start = 1'b1;
        a_in = 32'd100;
        b_in = 32'd7;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            div_start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_div_busy: got busy=%b at edge 15, want 1", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        $display("txn async reset mid-divide: hi=%h lo=%h busy=%b", hi_out, lo_out, busy);
        checks++;
        if ({hi_out, lo_out} !== 64'h0 || {busy, div_done, mult_done, div_zero} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b dd=%b md=%b dz=%b, want all 0",
                     hi_out, lo_out, busy, div_done, mult_done, div_zero);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, edges, sm, sd);
        $display("txn mult max*max: edges=%0d hi=%h lo=%h", edges, hi_out, lo_out);
        checks++;
        if (edges !== MUL_LAT || hi_out !== 32'h3FFF_FFFF || lo_out !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mult_max: got edges=%0d hi=%h lo=%h, want %0d/3fffffff/00000001",
                     edges, hi_out, lo_out, MUL_LAT);
        end
    endtask

    task automatic test_mult_boundary;
        int   edges;
        logic sm, sd;
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, edges, sm, sd);
        $display("txn mult min*-1: edges=%0d hi=%h lo=%h", edges, hi_out, lo_out);
        checks++;
        if (hi_out !== 32'h0 || lo_out !== 32'h8000_0000) begin
            failures++;
            $display("FAIL mult_min_x_-1: got hi=%h lo=%h, want 0/80000000", hi_out, lo_out);
        end
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0003, edges, sm, sd);
        $display("txn mult min*3: edges=%0d hi=%h lo=%h", edges, hi_out, lo_out);
        checks++;
        if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h8000_0000) begin
            failures++;
            $display("FAIL mult_min_x_3: got hi=%h lo=%h, want fffffffe/80000000", hi_out, lo_out);
        end
    endtask

    task automatic test_back_to_back;
        int   edges;
        logic sm, sd;
        run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, edges, sm, sd);
        $display("txn mult -2*-2: edges=%0d hi=%h lo=%h", edges, hi_out, lo_out);
        checks++;
        if (edges !== MUL_LAT || hi_out !== 32'h0 || lo_out !== 32'd4) begin
            failures++;
            $display("FAIL mult_-2x-2: got edges=%0d hi=%h lo=%h, want %0d/0/4", edges, hi_out, lo_out, MUL_LAT);
        end
        // Still in the done cycle: this start must be ignored
        @(negedge clk);
        div_start = 1'b1;
        a_in = 32'd9;
        b_in = 32'd0;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        checks++;
        if (div_done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done: got dd=%b busy=%b dz=%b, want 0/0/0", div_done, busy, div_zero);
        end
        // First IDLE cycle: earliest accepted start
        @(negedge clk);
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        $display("txn div 9/0 in first idle cycle: dd=%b hi=%h lo=%h dz=%b", div_done, hi_out, lo_out, div_zero);
        checks++;
        if (div_done !== 1'b1 || hi_out !== 32'd9 || lo_out !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
            failures++;
            $display("FAIL first_idle_start: got dd=%b hi=%h lo=%h dz=%b, want 1/00000009/ffffffff/1",
                     div_done, hi_out, lo_out, div_zero);
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_signed();
        test_div_overflow_zero();
        test_simultaneous();
        test_async_reset();
        test_mult_boundary();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
